// File: rtl/frame_relay.sv
// frame_relay: store-and-forward frame relay; buffers whole rx frames, drops bad/runt frames, paces tx with an inter-frame gap
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   rxd       - receive data, valid when rx_dv=1
//   rx_dv     - receive valid; a frame is a maximal run of rx_dv=1 samples
//   txd       - transmit data (registered, holds while tx_en=0)
//   tx_en     - transmit valid (registered), contiguous for one frame
//   drop_cnt  - dropped frames, saturating
//   frame_cnt - fully transmitted frames, wrapping
module frame_relay #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 64,
    parameter int MIN_LEN = 1,
    parameter int IFG     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rx_dv,
    output logic [DATA_W-1:0] txd,
    output logic              tx_en,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       frame_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int LW   = $clog2(DEPTH + 2);
    localparam int GAPN = (IFG < 1) ? 1 : IFG;
    localparam int GW   = $clog2(GAPN) + 1;
    // lengths saturate at DEPTH+1, so a larger minimum behaves the same as DEPTH+1
    localparam int MINC = (MIN_LEN > DEPTH + 1) ? DEPTH + 1 : MIN_LEN;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic              in_v_q, in_v_d, skip_q, skip_d;
    logic [DATA_W-1:0] in_d_q, in_d_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     len_q, len_d, len_n;
    logic              bad_q, bad_d, bad_n, full, wr_en, in_last;
    logic [15:0]       drop_q, drop_d, frame_q, frame_d;
    state_t            state_q, state_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic              tx_en_q, tx_en_d, pop;
    logic [DATA_W:0]   rd_word;

    assign txd       = txd_q;
    assign tx_en     = tx_en_q;
    assign drop_cnt  = drop_q;
    assign frame_cnt = frame_q;

    // receive side: one-stage input register, speculative write, commit or rewind at frame end
    always_comb begin
        // skip_q masks a frame already in progress when reset is released
        in_v_d   = rx_dv & ~skip_q;
        in_d_d   = rx_dv ? rxd : in_d_q;
        skip_d   = skip_q & rx_dv;
        wr_ptr_d = wr_ptr_q;
        wr_cmt_d = wr_cmt_q;
        len_d    = len_q;
        bad_d    = bad_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;
        in_last  = ~rx_dv;
        full     = (wr_ptr_q - rd_ptr_q) == {1'b1, {AW{1'b0}}};
        len_n    = (len_q == LW'(DEPTH + 1)) ? len_q : len_q + LW'(1);
        bad_n    = bad_q | full | (len_n > LW'(DEPTH));
        if (in_v_q) begin
            wr_en    = ~bad_n;
            wr_ptr_d = bad_n ? wr_ptr_q : wr_ptr_q + PW'(1);
            if (in_last) begin
                len_d = '0;
                bad_d = 1'b0;
                if (bad_n || len_n < LW'(MINC)) begin
                    wr_ptr_d = wr_cmt_q;
                    drop_d   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                end else begin
                    wr_cmt_d = wr_ptr_q + PW'(1);
                end
            end else begin
                len_d = len_n;
                bad_d = bad_n;
            end
        end
    end

    // transmit side: only committed entries are visible, so SEND never underruns
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        rd_ptr_d = rd_ptr_q;
        txd_d   = txd_q;
        tx_en_d = 1'b0;
        rd_word = mem_q[rd_ptr_q[AW-1:0]];
        pop     = (state_q == SEND) || (state_q == IDLE && rd_ptr_q != wr_cmt_q);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            txd_d    = rd_word[DATA_W-1:0];
            tx_en_d  = 1'b1;
            state_d  = rd_word[DATA_W] ? GAP : SEND;
            gcnt_d   = '0;
        end else if (state_q == GAP) begin
            gcnt_d  = gcnt_q + GW'(1);
            state_d = (gcnt_q == GW'(GAPN - 1)) ? IDLE : GAP;
        end
        frame_d = frame_q + 16'(tx_en_q & ~tx_en_d);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_d_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v_q   <= 1'b0;
            in_d_q   <= '0;
            skip_q   <= 1'b1;
            wr_ptr_q <= '0;
            wr_cmt_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            bad_q    <= 1'b0;
            drop_q   <= '0;
            frame_q  <= '0;
            state_q  <= IDLE;
            gcnt_q   <= '0;
            txd_q    <= '0;
            tx_en_q  <= 1'b0;
        end else begin
            in_v_q   <= in_v_d;
            in_d_q   <= in_d_d;
            skip_q   <= skip_d;
            wr_ptr_q <= wr_ptr_d;
            wr_cmt_q <= wr_cmt_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            bad_q    <= bad_d;
            drop_q   <= drop_d;
            frame_q  <= frame_d;
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            txd_q    <= txd_d;
            tx_en_q  <= tx_en_d;
        end
    end
endmodule

// File: tb/tb_frame_relay.sv
// tb_frame_relay: directed scoreboard bench for frame_relay across several parameter sets
module tb_frame_relay;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rxd_r [5];
    logic       dv_r  [5];
    logic [7:0] txd_w [5];
    logic       en_w  [5];
    logic [15:0] drop_w [5];
    logic [15:0] fcnt_w [5];

    logic [7:0] sb [5][$];
    int  errors = 0;
    int  checks = 0;
    int  low_run [5];
    int  min_gap [5];
    bit  seen [5];
    bit  prev_en [5];

    always #5 clk = ~clk;

    // u0 default, u1 IFG=3, u2 DEPTH=4, u3 MIN_LEN=3, u4 MIN_LEN=2
    frame_relay u0 (.clk(clk), .rst_n(rst_n), .rxd(rxd_r[0]), .rx_dv(dv_r[0]), .txd(txd_w[0]), .tx_en(en_w[0]), .drop_cnt(drop_w[0]), .frame_cnt(fcnt_w[0]));
    frame_relay #(.IFG(3)) u1 (.clk(clk), .rst_n(rst_n), .rxd(rxd_r[1]), .rx_dv(dv_r[1]), .txd(txd_w[1]), .tx_en(en_w[1]), .drop_cnt(drop_w[1]), .frame_cnt(fcnt_w[1]));
    frame_relay #(.DEPTH(4)) u2 (.clk(clk), .rst_n(rst_n), .rxd(rxd_r[2]), .rx_dv(dv_r[2]), .txd(txd_w[2]), .tx_en(en_w[2]), .drop_cnt(drop_w[2]), .frame_cnt(fcnt_w[2]));
    frame_relay #(.MIN_LEN(3)) u3 (.clk(clk), .rst_n(rst_n), .rxd(rxd_r[3]), .rx_dv(dv_r[3]), .txd(txd_w[3]), .tx_en(en_w[3]), .drop_cnt(drop_w[3]), .frame_cnt(fcnt_w[3]));
    frame_relay #(.MIN_LEN(2)) u4 (.clk(clk), .rst_n(rst_n), .rxd(rxd_r[4]), .rx_dv(dv_r[4]), .txd(txd_w[4]), .tx_en(en_w[4]), .drop_cnt(drop_w[4]), .frame_cnt(fcnt_w[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: sample 1ns after the edge, pop scoreboards for every active tx, track gaps
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (en_w[i]) begin
                checks++;
                assert (sb[i].size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_tx u%0d: got txd %0h expected no tx", i, txd_w[i]);
                end
                if (sb[i].size() != 0) begin
                    e = sb[i].pop_front();
                    chk($sformatf("txd_u%0d", i), 32'(txd_w[i]), 32'(e));
                end
                if (!prev_en[i] && seen[i] && low_run[i] < min_gap[i]) min_gap[i] = low_run[i];
                seen[i] = 1'b1;
                low_run[i] = 0;
            end else begin
                low_run[i]++;
            end
            prev_en[i] = en_w[i];
        end
    endtask

    // frame of n words base, base+11h, ...; the first npush are expected on tx
    task automatic send(input int i, input int n, input logic [7:0] base, input int npush);
        for (int k = 0; k < n; k++) begin
            rxd_r[i] = base + 8'(k * 8'h11);
            dv_r[i] = 1'b1;
            if (k < npush) sb[i].push_back(rxd_r[i]);
            tick();
        end
        dv_r[i] = 1'b0;
        tick();
    endtask

    task automatic drain(input int i);
        for (int c = 0; c < 80 && (sb[i].size() != 0 || en_w[i]); c++) tick();
        chk($sformatf("drain_u%0d", i), 32'(sb[i].size()), 32'd0);
        chk($sformatf("drain_en_u%0d", i), 32'(en_w[i]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rxd_r[i] = '0;
            dv_r[i] = 1'b0;
            low_run[i] = 0;
            min_gap[i] = 1000;
            seen[i] = 1'b0;
            prev_en[i] = 1'b0;
        end
        repeat (3) tick();
        chk("rst_tx_en", 32'(en_w[0]), 32'd0);
        chk("rst_txd", 32'(txd_w[0]), 32'd0);
        chk("rst_drop", 32'(drop_w[0]), 32'd0);
        chk("rst_fcnt", 32'(fcnt_w[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx_en", 32'(en_w[0]), 32'd0);

        // 4-word frame, latency and contiguity
        send(0, 4, 8'h11, 4);
        chk("lat_edge1_en", 32'(en_w[0]), 32'd0);
        tick();
        chk("lat_edge2_en", 32'(en_w[0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("contig_en", 32'(en_w[0]), 32'd1);
        end
        tick();
        chk("end_en", 32'(en_w[0]), 32'd0);
        chk("a_fcnt", 32'(fcnt_w[0]), 32'd1);
        chk("a_drop", 32'(drop_w[0]), 32'd0);

        // back-to-back frames with IFG=3
        send(1, 4, 8'hA0, 4);
        send(1, 3, 8'h05, 3);
        drain(1);
        chk("ifg_fcnt", 32'(fcnt_w[1]), 32'd2);
        chk("ifg_min_gap", 32'(min_gap[1]), 32'd3);

        // DEPTH=4: over-length frame dropped, next frame forwarded
        send(2, 6, 8'h01, 0);
        send(2, 3, 8'h70, 3);
        drain(2);
        chk("ovl_drop", 32'(drop_w[2]), 32'd1);
        chk("ovl_fcnt", 32'(fcnt_w[2]), 32'd1);

        // MIN_LEN=3: 2-word runt dropped, 3-word frame forwarded
        send(3, 2, 8'h30, 0);
        send(3, 3, 8'h40, 3);
        drain(3);
        chk("runt_drop", 32'(drop_w[3]), 32'd1);
        chk("runt_fcnt", 32'(fcnt_w[3]), 32'd1);

        // reset during the 2nd transmitted word
        send(0, 4, 8'h50, 2);
        tick();
        tick();
        chk("pre_rst_en", 32'(en_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(en_w[0]), 32'd0);
        chk("midrst_fcnt", 32'(fcnt_w[0]), 32'd0);
        chk("midrst_drop", 32'(drop_w[3]), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("flushed_en", 32'(en_w[0]), 32'd0);
        send(0, 3, 8'h21, 3);
        drain(0);
        chk("after_rst_fcnt", 32'(fcnt_w[0]), 32'd1);

        // saturation of drop_cnt with single-word runts
        for (int k = 1; k <= 70000; k++) begin
            rxd_r[4] = 8'(k);
            dv_r[4] = 1'b1;
            tick();
            dv_r[4] = 1'b0;
            tick();
            if (k == 65534) chk("sat_minus1", 32'(drop_w[4]), 32'hFFFE);
            if (k == 65535) chk("sat_reach", 32'(drop_w[4]), 32'hFFFF);
        end
        chk("sat_hold", 32'(drop_w[4]), 32'hFFFF);
        chk("sat_fcnt", 32'(fcnt_w[4]), 32'd0);

        for (int i = 0; i < 5; i++) chk($sformatf("sb_empty_u%0d", i), 32'(sb[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_relay.md
FRAME_RELAY -- requirements
Module: frame_relay

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bus width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, giving the buffer entries; it is a power of 2 and at least 4.
REQ-003 The block SHALL have parameter MIN_LEN, default 1, giving the minimum accepted frame length in words; shorter frames are dropped.
REQ-004 The block SHALL have parameter IFG, default 1, giving the minimum tx_en-low cycles between transmitted frames.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port rxd, input, DATA_W bits: receive data, valid when rx_dv=1.
REQ-008 The block SHALL have port rx_dv, input, 1 bit: receive valid; a frame is a maximal run of consecutive rx_dv=1 samples.
REQ-009 The block SHALL have port txd, output, DATA_W bits: transmit data, registered.
REQ-010 The block SHALL have port tx_en, output, 1 bit: transmit valid, registered; high for exactly the words of one frame, contiguous.
REQ-011 The block SHALL have port drop_cnt, output, 16 bits: count of dropped frames, saturating at 16'hFFFF.
REQ-012 The block SHALL have port frame_cnt, output, 16 bits: count of fully transmitted frames, wrapping modulo 2^16.

Function
REQ-013 The block SHALL operate store-and-forward: no word of a frame is transmitted before that frame's last word is committed.
REQ-014 The block SHALL register each rx_dv=1 sample into a one-stage input register and write it to the buffer on the next edge, tagged last=1 when rx_dv=0 at that edge, else last=0.
REQ-015 The block SHALL keep a speculative write pointer wr_ptr, a commit pointer wr_cmt and a read pointer rd_ptr, each clog2(DEPTH)+1 bits wide, wrapping; full when wr_ptr-rd_ptr==DEPTH.
REQ-016 On writing a last=1 word of a good frame, the block SHALL set wr_cmt to the post-write wr_ptr in the same edge.
REQ-017 A word arriving while the buffer is full SHALL mark the current frame bad; it and all remaining words of that frame SHALL be discarded.
REQ-018 At the end of a bad frame, or of a frame whose length is below MIN_LEN, the block SHALL rewind wr_ptr to wr_cmt and increment drop_cnt once.
REQ-019 The frame length counter SHALL saturate at DEPTH+1 so that over-length frames cannot wrap into an accepted length.
REQ-020 A frame longer than DEPTH SHALL always be dropped per REQ-017/REQ-018.
REQ-021 The TX state machine SHALL have states IDLE, SEND and GAP.
REQ-022 In IDLE with rd_ptr!=wr_cmt, the TX state machine SHALL pop one entry, drive txd=data with tx_en=1, and go to SEND, or to GAP if that entry has last=1.
REQ-023 In SEND, the TX state machine SHALL pop one entry per cycle with tx_en=1, and go to GAP after popping the last=1 entry.
REQ-024 In GAP, tx_en SHALL be 0 for max(IFG,1) cycles, after which the state machine returns to IDLE.
REQ-025 On the cycle tx_en drops after a frame, frame_cnt SHALL increment.
REQ-026 When tx_en=0, txd SHALL hold its last value.
REQ-027 Latency: with an empty buffer and TX in IDLE, tx_en SHALL rise on the 2nd rising edge after the edge sampling the frame's last word.
REQ-028 A write/commit and a pop in the same cycle SHALL both take effect, with full/empty evaluated on pre-edge pointers.
REQ-029 A rewind SHALL never move wr_ptr behind rd_ptr.
REQ-030 A single-word frame (rx_dv high for one cycle) SHALL be valid when MIN_LEN==1.

Reset
REQ-031 While rst_n=0, the block SHALL clear txd, tx_en, drop_cnt, frame_cnt, all pointers, the length counter and the bad flag, and set the state to IDLE.
REQ-032 Reset asserted mid-frame on RX or TX SHALL discard all buffered data; after release, the next rx_dv rising edge starts a new frame.
REQ-033 No output SHALL glitch to a non-reset value during the first edge after rst_n release.

Verification
REQ-034 Bench SHALL cover: defaults, a 4-word frame 11,22,33,44 -> tx_en high 4 contiguous cycles, 2 edges after word 44 sampled, txd 11..44, frame_cnt=1.
REQ-035 Bench SHALL cover: two back-to-back frames separated by one rx_dv=0 cycle, IFG=3 -> both forwarded intact, tx_en low at least 3 cycles between them.
REQ-036 Bench SHALL cover: DEPTH=4, 6-word frame -> no tx_en, drop_cnt=1; a following 3-word frame is forwarded correctly.
REQ-037 Bench SHALL cover: MIN_LEN=3, frames of 2 and 3 words -> only the 3-word frame transmitted, drop_cnt=1, frame_cnt=1.
REQ-038 Bench SHALL cover: rst_n pulsed low during the 2nd word of TX -> tx_en=0 immediately, counters 0, buffer empty; a new frame then forwards normally.
REQ-039 Bench SHALL cover: 70000 runt frames with MIN_LEN=2 -> drop_cnt saturates at 16'hFFFF.
